reference_index_sequencer: RTL and testbench
============================================

// Module: reference_index_sequencer
// PURPOSE
//  Initiator for the reference_buffer index/data interface. On start, issues BUFFER_LENGTH
//  index requests (shift+k) mod BUFFER_LENGTH, k=0..BUFFER_LENGTH-1, collects returned I/Q
//  samples and forwards them in order as a framed stream (tlast on final sample) toward the
//  CAF correlator. Credit-limits outstanding requests so no returned sample is ever dropped.
// PARAMETERS
//  BUFFER_LENGTH  32  samples in reference buffer (2..2**BUFFER_BITS)
//  BUFFER_BITS    5   index width
//  I_BITS         12  signed I sample width
//  Q_BITS         12  signed Q sample width
//  FIFO_DEPTH     4   output skid FIFO entries (power of 2, >=2); also max outstanding requests
// PORTS
//  clk                  in   1            rising-edge clock
//  reset                in   1            synchronous, active-high
//  start                in   1            begin a sweep (sampled only in IDLE)
//  shift                in   BUFFER_BITS  start offset, latched on accepted start
//  busy                 out  1            high from accepted start until done
//  done                 out  1            one-cycle pulse after last output handshake
//  m_axis_index_tvalid  out  1            index request valid
//  m_axis_index_tdata   out  BUFFER_BITS  requested index
//  m_axis_index_tready  in   1            buffer accepts index
//  s_axis_data_tvalid   in   1            returned sample valid
//  s_axis_data_tready   out  1            sequencer accepts sample
//  i                    in   I_BITS       returned I (signed)
//  q                    in   Q_BITS       returned Q (signed)
//  m_axis_data_tvalid   out  1            output sample valid
//  m_axis_data_tready   in   1            downstream accepts
//  m_axis_data_tdata    out  I_BITS+Q_BITS  {i,q}, I in MSBs
//  m_axis_data_tlast    out  1            high with sample BUFFER_LENGTH-1 of the sweep
// BEHAVIOUR
//  Reset: all valids 0, m_axis_index_tdata 0, tlast 0, busy 0, done 0, s_axis_data_tready 0,
//   FIFO emptied, counters 0, FSM->IDLE. Reset mid-sweep aborts; no done pulse.
//  FSM: IDLE -(start)-> ISSUE -(last index accepted)-> DRAIN -(last output handshake)-> DONE
//   -> IDLE (DONE lasts 1 cycle, done=1 there). start outside IDLE is ignored.
//  Shift latch: shift>=BUFFER_LENGTH latched as shift-BUFFER_LENGTH.
//  Index gen: idx starts at latched shift; after each accepted request (tvalid&tready)
//   idx<=idx+1, wrapping BUFFER_LENGTH-1 -> 0. Issue count req_cnt 0..BUFFER_LENGTH.
//  First m_axis_index_tvalid asserted cycle after start accepted. tvalid/tdata stable until
//   accepted (AXI-S rule). Back-to-back accepts allowed: one index/cycle max.
//  Credits: outstanding = requests accepted - samples received. tvalid asserted only when
//   req_cnt<BUFFER_LENGTH and outstanding+fifo_count<FIFO_DEPTH.
//  s_axis_data_tready=busy (credits guarantee FIFO space); samples arriving while not busy
//   are discarded.
//  Output: FIFO first-word-fall-through; m_axis_data_tvalid=!empty. Same-cycle push and pop
//   allowed, count unchanged. tlast tagged on sample number BUFFER_LENGTH-1 (0-based).
//  Output order = request order; buffer latency arbitrary but in-order.
//  Sweep latency: with tready always high and 1-cycle buffer, BUFFER_LENGTH+3 cycles
//   start->done.
//  Width: index add is BUFFER_BITS+1 wide before wrap compare; no truncation of i/q.
// TESTING
//  1 BUFFER_LENGTH=32, shift=0, all readies high -> indices 0..31 in order, 32 outputs, tlast
//    on 32nd only, done 1 cycle after, busy low after DONE.
//  2 shift=29 -> indices 29,30,31,0,1,..,28; output samples match buffer contents in that order.
//  3 m_axis_data_tready low 20 cycles mid-sweep -> index tvalid drops once outstanding+count=4;
//    no sample lost/duplicated; resumes on tready high.
//  4 m_axis_index_tready toggled random -> tdata held while tvalid&!tready; exactly 32 accepts.
//  5 start pulsed while busy and shift changed -> ignored, sweep uses original shift.
//  6 reset asserted at output 10 -> next cycle all valids 0, busy 0, no done; fresh start
//    runs full clean sweep of 32.

Source files
------------

// File: rtl/reference_index_sequencer.sv
// Sweeps reference_buffer indices from a shift offset and streams the
// returned I/Q samples out in request order, framed with tlast.
module reference_index_sequencer #(
  parameter int BUFFER_LENGTH = 32,
  parameter int BUFFER_BITS   = 5,
  parameter int I_BITS        = 12,
  parameter int Q_BITS        = 12,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [BUFFER_BITS-1:0]     shift,
  output logic                       busy,
  output logic                       done,
  output logic                       m_axis_index_tvalid,
  output logic [BUFFER_BITS-1:0]     m_axis_index_tdata,
  input  logic                       m_axis_index_tready,
  input  logic                       s_axis_data_tvalid,
  output logic                       s_axis_data_tready,
  input  logic signed [I_BITS-1:0]   i,
  input  logic signed [Q_BITS-1:0]   q,
  output logic                       m_axis_data_tvalid,
  input  logic                       m_axis_data_tready,
  output logic [I_BITS+Q_BITS-1:0]   m_axis_data_tdata,
  output logic                       m_axis_data_tlast
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;
  localparam int NW = BUFFER_BITS + 1;
  localparam int DW = I_BITS + Q_BITS;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t state, state_n;

  logic [BUFFER_BITS-1:0] idx, idx_next, shift_lat;
  logic [NW-1:0]          idx_inc, req_cnt, out_cnt;
  logic [CW-1:0]          outstanding, fifo_count;
  logic [SW-1:0]          credit_sum;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [DW-1:0]          mem [FIFO_DEPTH];
  logic start_acc, idx_hs, push, pop, empty, credit_ok;

  assign start_acc  = (state == IDLE) && start;
  assign idx_hs     = m_axis_index_tvalid && m_axis_index_tready;
  assign push       = s_axis_data_tvalid && s_axis_data_tready;
  assign pop        = !empty && m_axis_data_tready;
  assign empty      = (fifo_count == '0);
  assign credit_sum = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit_ok  = credit_sum < SW'(FIFO_DEPTH);

  assign s_axis_data_tready = busy;
  assign m_axis_index_tdata = idx;
  assign m_axis_data_tvalid = !empty;
  assign m_axis_data_tdata  = mem[rd_ptr];
  assign m_axis_data_tlast  =
    !empty && (out_cnt == NW'(BUFFER_LENGTH - 1));

  always_comb begin
    idx_inc = {1'b0, idx} + NW'(1);
    if (idx_inc == NW'(BUFFER_LENGTH)) idx_next = '0;
    else idx_next = idx + BUFFER_BITS'(1);
    if ({1'b0, shift} >= NW'(BUFFER_LENGTH))
      shift_lat = shift - BUFFER_BITS'(BUFFER_LENGTH);
    else
      shift_lat = shift;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = ISSUE;
      ISSUE:
        if (idx_hs && req_cnt == NW'(BUFFER_LENGTH - 1))
          state_n = DRAIN;
      DRAIN:
        if (pop && out_cnt == NW'(BUFFER_LENGTH - 1))
          state_n = DONE;
      DONE:  state_n = IDLE;
    endcase
  end

  // Index valid is credit-gated; once raised the credit sum cannot grow
  // until acceptance, so tvalid stays stable without a register.
  always_comb begin
    busy                = 1'b0;
    done                = 1'b0;
    m_axis_index_tvalid = 1'b0;
    unique case (state)
      IDLE: ;
      ISSUE: begin
        busy = 1'b1;
        m_axis_index_tvalid =
          (req_cnt < NW'(BUFFER_LENGTH)) && credit_ok;
      end
      DRAIN: busy = 1'b1;
      DONE:  done = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      req_cnt     <= '0;
      out_cnt     <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (start_acc) begin
        idx         <= shift_lat;
        req_cnt     <= '0;
        out_cnt     <= '0;
        outstanding <= '0;
      end else begin
        if (idx_hs) begin
          idx     <= idx_next;
          req_cnt <= req_cnt + NW'(1);
        end
        if (pop) out_cnt <= out_cnt + NW'(1);
        if (idx_hs && !push)
          outstanding <= outstanding + CW'(1);
        else if (!idx_hs && push)
          outstanding <= outstanding - CW'(1);
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        fifo_count <= fifo_count + CW'(1);
      else if (pop && !push)
        fifo_count <= fifo_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {i, q};
  end

endmodule

// File: tb/tb_reference_index_sequencer.sv
// Scoreboard bench: expected indices and samples queued per sweep,
// monitors pop and compare on each handshake.
module tb_reference_index_sequencer;

  localparam int BL = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, busy, done;
  logic [4:0] shift;
  logic idx_valid, idx_ready;
  logic [4:0] idx_data;
  logic s_valid, s_ready;
  logic signed [11:0] s_i, s_q;
  logic m_valid, m_ready, m_last;
  logic [23:0] m_data;

  reference_index_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .shift(shift),
    .busy(busy), .done(done),
    .m_axis_index_tvalid(idx_valid),
    .m_axis_index_tdata(idx_data),
    .m_axis_index_tready(idx_ready),
    .s_axis_data_tvalid(s_valid),
    .s_axis_data_tready(s_ready),
    .i(s_i), .q(s_q),
    .m_axis_data_tvalid(m_valid),
    .m_axis_data_tready(m_ready),
    .m_axis_data_tdata(m_data),
    .m_axis_data_tlast(m_last)
  );

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  logic [4:0]  exp_idx [$];
  logic [24:0] exp_dat [$];
  logic        prev_pend = 1'b0;
  logic [4:0]  prev_data = '0;

  function automatic logic [23:0] bufword(input int a);
    logic [11:0] wi, wq;
    wi = 12'(a * 37 - 600);
    wq = 12'(900 - a * 53);
    return {wi, wq};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference_buffer model: one-cycle, in-order read latency
  always @(posedge clk) begin
    if (reset) s_valid <= 1'b0;
    else begin
      s_valid <= idx_valid && idx_ready;
      {s_i, s_q} <= bufword(int'(idx_data));
    end
  end

  always @(negedge clk) begin
    if (reset) prev_pend = 1'b0;
    else begin
      if (prev_pend)
        chk("idx_hold", {26'd0, idx_valid, idx_data},
            {26'd0, 1'b1, prev_data});
      if (idx_valid)
        chk("credit", 32'(acc_cnt - pop_cnt < 4), 32'd1);
      if (idx_valid && idx_ready) begin
        acc_cnt++;
        if (exp_idx.size() == 0)
          chk("idx_extra", {27'd0, idx_data}, 32'hffff_ffff);
        else
          chk("idx_order", {27'd0, idx_data},
              {27'd0, exp_idx.pop_front()});
      end
      prev_pend = idx_valid && !idx_ready;
      prev_data = idx_data;
    end
  end

  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      pop_cnt++;
      if (exp_dat.size() == 0)
        chk("data_extra", {7'd0, m_data, m_last}, 32'hffff_ffff);
      else
        chk("data", {7'd0, m_data, m_last},
            {7'd0, exp_dat.pop_front()});
    end
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic load_expect(input logic [4:0] sh);
    acc_cnt = 0;
    pop_cnt = 0;
    for (int k = 0; k < BL; k++) begin
      exp_idx.push_back(5'((int'(sh) + k) % BL));
      exp_dat.push_back({bufword((int'(sh) + k) % BL), k == BL - 1});
    end
  endtask

  task automatic issue_start(input logic [4:0] sh);
    @(posedge clk); #1;
    start = 1'b1;
    shift = sh;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_sweep(input logic [4:0] sh, input bit stall,
                           input bit tog, input bit poke,
                           input bit chk_lat);
    logic [15:0] pat;
    int n;
    bit got;
    int d0;
    pat = 16'b1011_0010_1110_0101;
    n = 0;
    got = 0;
    d0 = done_cnt;
    load_expect(sh);
    issue_start(sh);
    while (n < 600 && !got) begin
      @(negedge clk);
      if (stall && n == 25) begin
        chk("throttle_idx_valid", {31'd0, idx_valid}, 32'd0);
        chk("throttle_m_valid", {31'd0, m_valid}, 32'd1);
      end
      if (done) got = 1;
      else begin
        @(posedge clk); #1;
        n++;
        idx_ready = tog ? pat[n % 16] : 1'b1;
        if (stall && n == 6)  m_ready = 1'b0;
        if (stall && n == 26) m_ready = 1'b1;
        if (poke && n == 5) begin
          start = 1'b1;
          shift = 5'd20;
        end
        if (poke && n == 6) start = 1'b0;
      end
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    if (chk_lat) chk("latency", 32'(n + 1), 32'(BL + 3));
    chk("idx_accepts", 32'(acc_cnt), 32'(BL));
    chk("outputs", 32'(pop_cnt), 32'(BL));
    chk("idx_left", 32'(exp_idx.size()), 32'd0);
    chk("data_left", 32'(exp_dat.size()), 32'd0);
    @(negedge clk);
    chk("done_pulse", {30'd0, done, busy}, 32'd0);
    chk("done_count", 32'(done_cnt - d0), 32'd1);
    idx_ready = 1'b1;
    m_ready = 1'b1;
    exp_idx.delete();
    exp_dat.delete();
  endtask

  task automatic run_abort(input logic [4:0] sh);
    int n;
    int d0;
    n = 0;
    d0 = done_cnt;
    load_expect(sh);
    issue_start(sh);
    while (pop_cnt < 10 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reach10", 32'(pop_cnt >= 10), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_idx.delete();
    exp_dat.delete();
    @(negedge clk);
    chk("abort_outputs",
        {27'd0, busy, done, idx_valid, m_valid, s_ready}, 32'd0);
    chk("abort_last", {31'd0, m_last}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    shift = '0;
    idx_ready = 1'b1;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", {30'd0, busy, done}, 32'd0);
    chk("reset_idx", {26'd0, idx_valid, idx_data}, 32'd0);
    chk("reset_data", {29'd0, m_valid, m_last, s_ready}, 32'd0);

    run_sweep(5'd0,  0, 0, 0, 1);
    run_sweep(5'd29, 0, 0, 0, 1);
    run_sweep(5'd4,  1, 0, 0, 0);
    run_sweep(5'd17, 0, 1, 0, 0);
    run_sweep(5'd7,  0, 0, 1, 0);
    run_abort(5'd3);
    run_sweep(5'd11, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
